// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// flush-counter width, the bundle of pipeline control strobes and the NOP word.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_RUN   = 2'd0,
      CTRL_STALL = 2'd1,
      CTRL_FLUSH = 2'd2,
      CTRL_WAIT  = 2'd3
   } ctrl_state_e;

   // Instruction word that IF/ID takes on a flush (addi x0, x0, 0).
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   // Width of the flush-cycle down-counter; covers FLUSH_CYCLES up to 15.
   localparam int FCNT_W = 4;

   // Every control strobe the controller drives into the pipeline.
   typedef struct packed {
      logic pc_load;
      logic pc_hold;
      logic if_id_hold;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running performance counter: counts enabled cycles, wraps at 2^CNT_W.
module pipe_ctrl_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: advance by one when enabled, natural wrap on overflow.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage core. Arbitrates redirect,
// busy EX unit and load-use hazards (in that priority) into hold/flush strobes
// for the PC, IF/ID and ID/EX registers, and counts lost cycles.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             jump_en_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             busy_i,
   input  logic             load_use_i,
   output logic             pc_load_o,
   output logic [31:0]      pc_target_o,
   output logic             pc_hold_o,
   output logic             if_id_hold_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   import pipe_ctrl_pkg::*;

   // Value loaded into the flush counter on a redirect; the redirect cycle
   // itself is the first flush cycle, so FLUSH covers the remainder.
   localparam logic [FCNT_W-1:0] RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

   ctrl_state_e       state_q, state_d;
   logic [FCNT_W-1:0] cnt_q, cnt_d;
   ctrl_t             ctrl;

   // State and flush counter registers; reset forces RUN at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CTRL_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and control strobes. A redirect wins in every state; busy and
   // load-use are only honoured where the offending instruction survives.
   always_comb begin
      ctrl    = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (jump_en_i) begin
         ctrl.pc_load     = 1'b1;
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = CTRL_FLUSH;
            cnt_d   = RELOAD;
         end else begin
            state_d = CTRL_RUN;
         end
      end else begin
         case (state_q)
            CTRL_RUN: begin
               if (busy_i) begin
                  ctrl.pc_hold     = 1'b1;
                  ctrl.if_id_hold  = 1'b1;
                  ctrl.id_ex_flush = 1'b1;
                  state_d          = CTRL_WAIT;
               end else if (load_use_i) begin
                  ctrl.pc_hold     = 1'b1;
                  ctrl.if_id_hold  = 1'b1;
                  ctrl.id_ex_flush = 1'b1;
                  state_d          = CTRL_STALL;
               end
            end
            // One bubble already inserted; never stall twice in a row.
            CTRL_STALL: begin
               state_d = CTRL_RUN;
            end
            CTRL_FLUSH: begin
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
               cnt_d            = cnt_q - FCNT_W'(1);
               if (cnt_q <= FCNT_W'(1)) begin
                  state_d = CTRL_RUN;
               end
            end
            CTRL_WAIT: begin
               if (busy_i) begin
                  ctrl.pc_hold     = 1'b1;
                  ctrl.if_id_hold  = 1'b1;
                  ctrl.id_ex_flush = 1'b1;
               end else begin
                  state_d = CTRL_RUN;
               end
            end
            default: begin
               state_d = CTRL_RUN;
            end
         endcase
      end
   end

   // Outputs are gated by reset so they drop the instant reset asserts,
   // even while hazard inputs are still active.
   assign pc_load_o     = rst_n & ctrl.pc_load;
   assign pc_hold_o     = rst_n & ctrl.pc_hold;
   assign if_id_hold_o  = rst_n & ctrl.if_id_hold;
   assign if_id_flush_o = rst_n & ctrl.if_id_flush;
   assign id_ex_flush_o = rst_n & ctrl.id_ex_flush;
   assign pc_target_o   = rst_n ? jump_addr_i : 32'h0;
   assign state_o       = state_q;

   pipe_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pc_hold_o),
      .cnt_o (stall_cnt_o)
   );

   pipe_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (if_id_flush_o),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Three instances share the stimulus and differ
// only in FLUSH_CYCLES (3, 4 and 1); each scenario checks the relevant one.
module tb_pipe_ctrl;

   // Control vector layout: {pc_load, pc_hold, if_id_hold, if_id_flush, id_ex_flush}
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_HOLD = 5'b01101;
   localparam logic [4:0] C_JUMP = 5'b10011;
   localparam logic [4:0] C_FLSH = 5'b00011;

   logic        clk;
   logic        rst_n;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        busy;
   logic        load_use;

   logic        pc_load_a, pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a;
   logic [31:0] pc_target_a, stall_cnt_a, flush_cnt_a;
   logic [1:0]  state_a;
   logic        pc_load_b, pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b;
   logic [31:0] pc_target_b, stall_cnt_b, flush_cnt_b;
   logic [1:0]  state_b;
   logic        pc_load_c, pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c;
   logic [31:0] pc_target_c, stall_cnt_c, flush_cnt_c;
   logic [1:0]  state_c;

   logic [4:0] ctl_a, ctl_b, ctl_c;
   assign ctl_a = {pc_load_a, pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a};
   assign ctl_b = {pc_load_b, pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b};
   assign ctl_c = {pc_load_c, pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c};

   int total;
   int bad;

   pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .busy_i(busy), .load_use_i(load_use), .pc_load_o(pc_load_a),
      .pc_target_o(pc_target_a), .pc_hold_o(pc_hold_a), .if_id_hold_o(if_id_hold_a),
      .if_id_flush_o(if_id_flush_a), .id_ex_flush_o(id_ex_flush_a), .state_o(state_a),
      .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
   );

   pipe_ctrl #(.FLUSH_CYCLES(4), .CNT_W(32)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .busy_i(busy), .load_use_i(load_use), .pc_load_o(pc_load_b),
      .pc_target_o(pc_target_b), .pc_hold_o(pc_hold_b), .if_id_hold_o(if_id_hold_b),
      .if_id_flush_o(if_id_flush_b), .id_ex_flush_o(id_ex_flush_b), .state_o(state_b),
      .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
   );

   pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .busy_i(busy), .load_use_i(load_use), .pc_load_o(pc_load_c),
      .pc_target_o(pc_target_c), .pc_hold_o(pc_hold_c), .if_id_hold_o(if_id_hold_c),
      .if_id_flush_o(if_id_flush_c), .id_ex_flush_o(id_ex_flush_c), .state_o(state_c),
      .stall_cnt_o(stall_cnt_c), .flush_cnt_o(flush_cnt_c)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle all inputs, pulse reset across two edges, release away from the edge.
   task automatic do_reset();
      rst_n     = 1'b0;
      jump_en   = 1'b0;
      busy      = 1'b0;
      load_use  = 1'b0;
      jump_addr = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // Reset holds everything at zero even with every hazard input active.
   task automatic test_reset();
      rst_n     = 1'b0;
      jump_en   = 1'b1;
      busy      = 1'b1;
      load_use  = 1'b1;
      jump_addr = 32'hDEAD_BEEF;
      #1;
      total++;
      if (ctl_a !== C_NONE) begin
         bad++; $display("FAIL reset_ctl got %b exp %b", ctl_a, C_NONE);
      end
      total++;
      if (pc_target_a !== 32'h0) begin
         bad++; $display("FAIL reset_target got %h exp %h", pc_target_a, 32'h0);
      end
      tick();
      total++;
      if (state_a !== 2'd0 || stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0) begin
         bad++; $display("FAIL reset_regs got st=%0d sc=%0d fc=%0d exp 0 0 0",
                         state_a, stall_cnt_a, flush_cnt_a);
      end
      do_reset();
   endtask

   // Continuous load-use: stall, free cycle, stall; never two in a row.
   task automatic test_load_use();
      logic [4:0] exp_ctl [3];
      logic [1:0] exp_st  [3];
      exp_ctl = '{C_HOLD, C_NONE, C_HOLD};
      exp_st  = '{2'd0, 2'd1, 2'd0};
      do_reset();
      load_use = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ctl_a !== exp_ctl[i] || state_a !== exp_st[i]) begin
            bad++; $display("FAIL lu_cycle%0d got ctl=%b st=%0d exp ctl=%b st=%0d",
                            i, ctl_a, state_a, exp_ctl[i], exp_st[i]);
         end
         tick();
      end
      load_use = 1'b0;
      #1;
      total++;
      if (state_a !== 2'd1 || ctl_a !== C_NONE) begin
         bad++; $display("FAIL lu_end got ctl=%b st=%0d exp ctl=%b st=1", ctl_a, state_a, C_NONE);
      end
      total++;
      if (stall_cnt_a !== 32'd2) begin
         bad++; $display("FAIL lu_stall_cnt got %0d exp 2", stall_cnt_a);
      end
   endtask

   // Single redirect with FLUSH_CYCLES=3: one load, three flush cycles.
   task automatic test_jump();
      do_reset();
      jump_en   = 1'b1;
      jump_addr = 32'h0000_0100;
      #1;
      total++;
      if (ctl_a !== C_JUMP || pc_target_a !== 32'h100) begin
         bad++; $display("FAIL jump_issue got ctl=%b tgt=%h exp ctl=%b tgt=00000100",
                         ctl_a, pc_target_a, C_JUMP);
      end
      tick();
      jump_en   = 1'b0;
      jump_addr = 32'h0000_0055;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (ctl_a !== C_FLSH || state_a !== 2'd2) begin
            bad++; $display("FAIL jump_flush%0d got ctl=%b st=%0d exp ctl=%b st=2",
                            i, ctl_a, state_a, C_FLSH);
         end
         tick();
      end
      #1;
      total++;
      if (ctl_a !== C_NONE || state_a !== 2'd0) begin
         bad++; $display("FAIL jump_done got ctl=%b st=%0d exp ctl=%b st=0", ctl_a, state_a, C_NONE);
      end
      total++;
      if (flush_cnt_a !== 32'd3 || stall_cnt_a !== 32'd0) begin
         bad++; $display("FAIL jump_cnts got fc=%0d sc=%0d exp 3 0", flush_cnt_a, stall_cnt_a);
      end
   endtask

   // Busy for 5 cycles with load-use pending: WAIT absorbs it, then one stall.
   task automatic test_busy();
      do_reset();
      busy     = 1'b1;
      load_use = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (ctl_a !== C_HOLD || state_a !== ((i == 0) ? 2'd0 : 2'd3)) begin
            bad++; $display("FAIL busy_cycle%0d got ctl=%b st=%0d exp ctl=%b st=%0d",
                            i, ctl_a, state_a, C_HOLD, (i == 0) ? 0 : 3);
         end
         tick();
      end
      busy = 1'b0;
      #1;
      total++;
      if (ctl_a !== C_NONE || state_a !== 2'd3) begin
         bad++; $display("FAIL busy_release got ctl=%b st=%0d exp ctl=%b st=3", ctl_a, state_a, C_NONE);
      end
      tick();
      #1;
      total++;
      if (ctl_a !== C_HOLD || state_a !== 2'd0) begin
         bad++; $display("FAIL busy_then_lu got ctl=%b st=%0d exp ctl=%b st=0", ctl_a, state_a, C_HOLD);
      end
      tick();
      load_use = 1'b0;
      #1;
      total++;
      if (stall_cnt_a !== 32'd6 || state_a !== 2'd1) begin
         bad++; $display("FAIL busy_stall_cnt got sc=%0d st=%0d exp sc=6 st=1", stall_cnt_a, state_a);
      end
   endtask

   // All three hazards at once: only the redirect acts.
   task automatic test_priority();
      do_reset();
      jump_en   = 1'b1;
      busy      = 1'b1;
      load_use  = 1'b1;
      jump_addr = 32'h0000_0A00;
      #1;
      total++;
      if (ctl_a !== C_JUMP || ctl_c !== C_JUMP) begin
         bad++; $display("FAIL prio_ctl got a=%b c=%b exp %b", ctl_a, ctl_c, C_JUMP);
      end
      tick();
      jump_en  = 1'b0;
      busy     = 1'b0;
      load_use = 1'b0;
      #1;
      total++;
      if (state_a !== 2'd2 || state_c !== 2'd0) begin
         bad++; $display("FAIL prio_state got a=%0d c=%0d exp a=2 c=0", state_a, state_c);
      end
      total++;
      if (ctl_c !== C_NONE || flush_cnt_c !== 32'd1 || stall_cnt_a !== 32'd0) begin
         bad++; $display("FAIL prio_fc1 got ctl=%b fc=%0d sc_a=%0d exp ctl=%b fc=1 sc_a=0",
                         ctl_c, flush_cnt_c, stall_cnt_a, C_NONE);
      end
   endtask

   // FLUSH_CYCLES=4, second redirect in flush cycle 2: reload gives 5 flush cycles.
   task automatic test_back_to_back();
      logic [4:0] exp_ctl [6];
      logic [1:0] exp_st  [6];
      int         loads;
      exp_ctl = '{C_JUMP, C_JUMP, C_FLSH, C_FLSH, C_FLSH, C_NONE};
      exp_st  = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      loads   = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         jump_en   = (i < 2);
         jump_addr = (i == 0) ? 32'h0000_0200 : 32'h0000_0300;
         #1;
         if (pc_load_b) loads++;
         total++;
         if (ctl_b !== exp_ctl[i] || state_b !== exp_st[i]) begin
            bad++; $display("FAIL b2b_cycle%0d got ctl=%b st=%0d exp ctl=%b st=%0d",
                            i, ctl_b, state_b, exp_ctl[i], exp_st[i]);
         end
         if (i == 1) begin
            total++;
            if (pc_target_b !== 32'h300) begin
               bad++; $display("FAIL b2b_target got %h exp 00000300", pc_target_b);
            end
         end
         tick();
      end
      jump_en = 1'b0;
      total++;
      if (flush_cnt_b !== 32'd5 || loads != 2) begin
         bad++; $display("FAIL b2b_totals got fc=%0d loads=%0d exp fc=5 loads=2", flush_cnt_b, loads);
      end
   endtask

   // Reset mid-WAIT: outputs and counters clear at once, WAIT re-entered after.
   task automatic test_reset_mid_wait();
      do_reset();
      busy = 1'b1;
      tick();
      tick();
      total++;
      if (state_a !== 2'd3 || stall_cnt_a !== 32'd2) begin
         bad++; $display("FAIL rmw_pre got st=%0d sc=%0d exp st=3 sc=2", state_a, stall_cnt_a);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (ctl_a !== C_NONE || state_a !== 2'd0 || stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0) begin
         bad++; $display("FAIL rmw_async got ctl=%b st=%0d sc=%0d fc=%0d exp 0 0 0 0",
                         ctl_a, state_a, stall_cnt_a, flush_cnt_a);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (ctl_a !== C_HOLD || state_a !== 2'd0) begin
         bad++; $display("FAIL rmw_release got ctl=%b st=%0d exp ctl=%b st=0", ctl_a, state_a, C_HOLD);
      end
      tick();
      total++;
      if (state_a !== 2'd3 || stall_cnt_a !== 32'd1) begin
         bad++; $display("FAIL rmw_rewait got st=%0d sc=%0d exp st=3 sc=1", state_a, stall_cnt_a);
      end
      busy = 1'b0;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load_use();
      test_jump();
      test_busy();
      test_priority();
      test_back_to_back();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
